motor_driver: RTL and testbench
===============================

# motor_driver

Consumes the 3-bit drive command and valid strobe issued by the steering logic and turns them into PWM and direction signals for the two H-bridge motor channels of the robot. Each wheel ramps its duty toward a per-command target. A wheel that must reverse direction first ramps to zero, then holds a dead-time with both bridge inputs low before flipping. A watchdog forces Stop if no valid command arrives for a set time.

## Interface
- PWM_BITS, 8: width of PWM counter and duty values; PWM period is 2^PWM_BITS cycles.
- DUTY_CRUISE, 192: forward duty for the outer or straight wheel.
- DUTY_SLOW, 96: forward duty for the inner wheel on Left/Right.
- DUTY_TURN, 160: duty for both wheels on a spin (Fast_left/Fast_right).
- RAMP_STEP, 16: duty change per ramp tick.
- RAMP_DIV, 1024: cycles between ramp ticks.
- DEADTIME, 256: cycles with both bridge inputs low during a reversal.
- WATCHDOG_CYCLES, 2_500_000: cycles without valid before a forced Stop.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- drive_command  in  3  0 Stop, 1 Fast_left, 2 Left, 3 Straight, 4 Right, 5 Fast_right; 6 and 7 are treated as Stop.
- valid  in  1  drive_command is sampled on every clk edge where valid=1.
- motor_l  out  2  left bridge {in1,in2}: 10 forward PWM, 01 reverse PWM, 00 coast.
- motor_r  out  2  right bridge, same encoding.
- stopped  out  1  both wheels in IDLE.
- timeout  out  1  watchdog expired; cleared by the next valid.

## Operation
- **Command latch:** a registered command updates on valid=1, giving target {dir,duty} per wheel.
  - Stop: both duty 0.
  - Fast_left: L reverse TURN, R forward TURN.
  - Left: L fwd SLOW, R fwd CRUISE.
  - Straight: both fwd CRUISE.
  - Right: L fwd CRUISE, R fwd SLOW.
  - Fast_right: L fwd TURN, R reverse TURN.
- **Watchdog:** the counter clears on valid. On reaching WATCHDOG_CYCLES it latches command=Stop and sets timeout=1. It saturates; no wrap.
- **Ramp tick:** a shared divider pulses one cycle every RAMP_DIV cycles.
- **Per-wheel FSM:** states IDLE, RUN, BRAKE, DEAD.
  - IDLE: duty=0, output 00. Go to RUN with dir=target dir when target duty>0.
  - RUN: on each tick, duty moves toward the target by min(RAMP_STEP, |diff|), saturating at the target.
    - Target dir differs from current dir: go to BRAKE.
    - Target duty=0 and duty reaches 0: go to IDLE.
  - BRAKE: target treated as 0; ramps down on ticks.
    - Target dir reverts to current dir: return to RUN.
    - Duty reaches 0: go to DEAD.
  - DEAD: output 00 for exactly DEADTIME cycles. Then dir=target dir at that cycle, then RUN if target duty>0, else IDLE.
- **PWM:** one free-running PWM_BITS counter is shared by both wheels.
  - Each wheel copies its working duty into an applied duty only when the counter wraps to 0.
  - pwm = counter < applied duty. Duty 0 gives constant low; the maximum is (2^PWM_BITS−1)/2^PWM_BITS.
- **Bridge output:** in1 = pwm & dir_fwd & !DEAD; in2 = pwm & !dir_fwd & !DEAD. in1 and in2 are never both 1.

## Timing
- Reset:
  - motor_l=motor_r=00, stopped=1, timeout=0.
  - command=Stop; all counters 0; wheels IDLE with dir=forward.
- Command latency: valid at edge N updates the target visible at edge N+1. The first duty change happens at the next ramp tick.
- Applied duty lags working duty by up to 2^PWM_BITS cycles; PWM is glitch-free within a period.
- Outputs are registered: one cycle from PWM compare to pins.
- A valid in the same cycle as watchdog expiry wins: no timeout, and the new command is latched.
- A reset asserted mid-operation forces outputs to 00 immediately, since reset is asynchronous.
- The worst-case reversal from CRUISE is ceil(192/16)=12 ticks, then DEADTIME cycles, then a ramp up.

## Structure
- Package motor_pkg holds:
  - enum drive_cmd_t {Stop, Fast_left, Left, Straight, Right, Fast_right}, which the steering logic must also import;
  - enum wheel_state_t {IDLE, RUN, BRAKE, DEAD};
  - the 2-bit bridge encoding constants.
- Sub-module wheel_channel holds one wheel's FSM, ramp, dead-time counter, applied-duty register and bridge output. It is instantiated twice; the top level holds the command latch, watchdog, ramp divider and PWM counter.

## Test plan
Scenarios use PWM_BITS=4, RAMP_DIV=4, RAMP_STEP=4, DEADTIME=8, WATCHDOG_CYCLES=200, DUTY_CRUISE=12, DUTY_SLOW=6, DUTY_TURN=8.
- Straight after reset -> both wheels ramp 0,4,8,12 on ticks; at steady state motor_l=motor_r=10 for 12 of 16 cycles; stopped falls.
- Left -> left settles at 6/16 high and right at 12/16, both forward.
- Straight, then settled, then Fast_left -> left ramps 12→0, outputs 00 for 8 cycles, then reverse (01) ramps to 8; right ramps down to 8 forward; in1&in2 is never 1.
- Fast_left issued during BRAKE, then Straight reissued before duty reaches 0 -> returns to RUN forward with no DEAD period.
- Straight, then valid held low for 200 cycles -> timeout=1, both wheels ramp to IDLE, stopped=1; the next valid clears timeout.
- drive_command=7 with valid -> behaves as Stop; reset pulse mid-ramp -> outputs 00 the same cycle and stopped=1.

Source files
------------

// File: rtl/motor_pkg.sv
// motor_pkg: shared types for the motor driver and the steering logic.
//   drive_cmd_t   - 3-bit drive command issued by the steering logic.
//   wheel_state_t - per-wheel ramp/reversal FSM state.
//   BRIDGE_*      - 2-bit H-bridge encodings {in1,in2}.
//   decode_cmd    - maps a raw 3-bit command to drive_cmd_t; codes 6/7 become Stop.
package motor_pkg;

  typedef enum logic [2:0] {
    Stop       = 3'd0,
    Fast_left  = 3'd1,
    Left       = 3'd2,
    Straight   = 3'd3,
    Right      = 3'd4,
    Fast_right = 3'd5
  } drive_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    BRAKE = 2'd2,
    DEAD  = 2'd3
  } wheel_state_t;

  localparam logic [1:0] BRIDGE_COAST = 2'b00;
  localparam logic [1:0] BRIDGE_FWD   = 2'b10;
  localparam logic [1:0] BRIDGE_REV   = 2'b01;

  function automatic drive_cmd_t decode_cmd(input logic [2:0] raw);
    drive_cmd_t c;
    case (raw)
      3'd1:    c = Fast_left;
      3'd2:    c = Left;
      3'd3:    c = Straight;
      3'd4:    c = Right;
      3'd5:    c = Fast_right;
      default: c = Stop;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/motor_driver_wheel.sv
// wheel_channel: one H-bridge channel.
//   Holds the IDLE/RUN/BRAKE/DEAD FSM, the duty ramp, the dead-time counter,
//   the applied-duty register (updated at PWM wrap) and the registered bridge.
// Ports:
//   clk, reset   - clock, async active-high reset
//   tick_i       - one-cycle ramp tick from the shared divider
//   wrap_i       - shared PWM counter is at its last count (wraps next edge)
//   pwm_cnt_i    - shared PWM counter value
//   tgt_fwd_i    - target direction (1 = forward)
//   tgt_duty_i   - target duty
//   bridge_o     - registered {in1,in2}
//   idle_o       - wheel is in IDLE
module wheel_channel
  import motor_pkg::*;
#(
  parameter int PWM_BITS  = 8,
  parameter int RAMP_STEP = 16,
  parameter int DEADTIME  = 256
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick_i,
  input  logic                wrap_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  input  logic                tgt_fwd_i,
  input  logic [PWM_BITS-1:0] tgt_duty_i,
  output logic [1:0]          bridge_o,
  output logic                idle_o
);

  localparam int DEAD_W = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [DEAD_W-1:0]   DEAD_LAST = DEAD_W'(DEADTIME - 1);
  // RAMP_STEP is expected to be below 2^PWM_BITS.
  localparam logic [PWM_BITS-1:0] STEP      = PWM_BITS'(RAMP_STEP);

  wheel_state_t        state_q, state_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic                fwd_q, fwd_d;
  logic [DEAD_W-1:0]   dead_q, dead_d;
  logic [PWM_BITS-1:0] applied_q, applied_d;
  logic [1:0]          bridge_q, bridge_d;

  logic                rev_req;
  logic [PWM_BITS-1:0] ramped, braked;
  logic                pwm_on, coast;

  // Move cur toward tgt by at most STEP, landing exactly on tgt.
  function automatic logic [PWM_BITS-1:0] ramp_to(input logic [PWM_BITS-1:0] cur,
                                                  input logic [PWM_BITS-1:0] tgt);
    logic [PWM_BITS-1:0] diff;
    logic [PWM_BITS-1:0] res;
    if (cur < tgt) begin
      diff = tgt - cur;
      res  = (diff > STEP) ? cur + STEP : tgt;
    end else begin
      diff = cur - tgt;
      res  = (diff > STEP) ? cur - STEP : tgt;
    end
    return res;
  endfunction

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    fwd_d   = fwd_q;
    dead_d  = dead_q;
    // A zero target carries no direction, so Stop ramps down in place
    // instead of going through a reversal.
    rev_req = (tgt_duty_i != '0) && (tgt_fwd_i != fwd_q);
    ramped  = ramp_to(duty_q, tgt_duty_i);
    braked  = ramp_to(duty_q, '0);
    case (state_q)
      IDLE: begin
        duty_d = '0;
        if (tgt_duty_i != '0) begin
          state_d = RUN;
          fwd_d   = tgt_fwd_i;
        end
      end
      RUN: begin
        if (rev_req) begin
          state_d = BRAKE;
        end else if (tick_i) begin
          duty_d = ramped;
          if ((tgt_duty_i == '0) && (ramped == '0)) state_d = IDLE;
        end
      end
      BRAKE: begin
        if (!rev_req) begin
          state_d = RUN;
        end else if (tick_i) begin
          duty_d = braked;
          if (braked == '0) begin
            state_d = DEAD;
            dead_d  = '0;
          end
        end
      end
      DEAD: begin
        if (dead_q == DEAD_LAST) begin
          fwd_d   = tgt_fwd_i;
          state_d = (tgt_duty_i != '0) ? RUN : IDLE;
        end else begin
          dead_d = dead_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Applied duty only changes at the period boundary so a pulse is never cut
  // or stretched. In IDLE/DEAD it is cleared at once: the output is gated
  // there anyway, and a stale duty must not leak out after a direction flip.
  always_comb begin
    applied_d = applied_q;
    if ((state_q == IDLE) || (state_q == DEAD)) applied_d = '0;
    else if (wrap_i)                            applied_d = duty_q;
  end

  assign pwm_on = (pwm_cnt_i < applied_q);
  assign coast  = (state_q == IDLE) || (state_q == DEAD);

  always_comb begin
    bridge_d = BRIDGE_COAST;
    if (!coast && pwm_on) bridge_d = fwd_q ? BRIDGE_FWD : BRIDGE_REV;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      duty_q    <= '0;
      fwd_q     <= 1'b1;
      dead_q    <= '0;
      applied_q <= '0;
      bridge_q  <= BRIDGE_COAST;
    end else begin
      state_q   <= state_d;
      duty_q    <= duty_d;
      fwd_q     <= fwd_d;
      dead_q    <= dead_d;
      applied_q <= applied_d;
      bridge_q  <= bridge_d;
    end
  end

  assign bridge_o = bridge_q;
  assign idle_o   = (state_q == IDLE);

endmodule

// File: rtl/motor_driver.sv
// motor_driver: two-channel H-bridge driver for the robot wheels.
//   Latches the steering command, runs the watchdog, the shared ramp divider
//   and the shared PWM counter, and feeds per-wheel targets to two
//   wheel_channel instances.
// Ports:
//   clk, reset     - clock, async active-high reset
//   drive_command  - 3-bit drive_cmd_t code (6/7 treated as Stop)
//   valid          - command strobe, sampled every edge
//   motor_l/_r     - bridge {in1,in2}: 10 fwd PWM, 01 rev PWM, 00 coast
//   stopped        - both wheels IDLE
//   timeout        - watchdog expired; cleared by the next valid
module motor_driver
  import motor_pkg::*;
#(
  parameter int PWM_BITS        = 8,
  parameter int DUTY_CRUISE     = 192,
  parameter int DUTY_SLOW       = 96,
  parameter int DUTY_TURN       = 160,
  parameter int RAMP_STEP       = 16,
  parameter int RAMP_DIV        = 1024,
  parameter int DEADTIME        = 256,
  parameter int WATCHDOG_CYCLES = 2_500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] drive_command,
  input  logic       valid,
  output logic [1:0] motor_l,
  output logic [1:0] motor_r,
  output logic       stopped,
  output logic       timeout
);

  localparam int WD_W  = $clog2(WATCHDOG_CYCLES + 1);
  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [WD_W-1:0]     WD_LIMIT = WD_W'(WATCHDOG_CYCLES);
  localparam logic [WD_W-1:0]     WD_LAST  = WD_W'(WATCHDOG_CYCLES - 1);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(RAMP_DIV - 1);
  localparam logic [PWM_BITS-1:0] D_CRUISE = PWM_BITS'(DUTY_CRUISE);
  localparam logic [PWM_BITS-1:0] D_SLOW   = PWM_BITS'(DUTY_SLOW);
  localparam logic [PWM_BITS-1:0] D_TURN   = PWM_BITS'(DUTY_TURN);

  drive_cmd_t          cmd_q, cmd_d;
  logic                timeout_q, timeout_d;
  logic [WD_W-1:0]     wd_cnt_q, wd_cnt_d;
  logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

  logic                tick, pwm_wrap;
  logic                tl_fwd, tr_fwd;
  logic [PWM_BITS-1:0] tl_duty, tr_duty;
  logic                idle_l, idle_r;

  // Command latch and watchdog. A valid in the expiry cycle takes priority,
  // so the watchdog only fires after a full WATCHDOG_CYCLES of silence.
  // The counter parks at WD_LIMIT so timeout holds until the next valid.
  always_comb begin
    cmd_d     = cmd_q;
    timeout_d = timeout_q;
    wd_cnt_d  = wd_cnt_q;
    if (valid) begin
      cmd_d     = decode_cmd(drive_command);
      timeout_d = 1'b0;
      wd_cnt_d  = '0;
    end else if (wd_cnt_q != WD_LIMIT) begin
      wd_cnt_d = wd_cnt_q + 1'b1;
      if (wd_cnt_q == WD_LAST) begin
        cmd_d     = Stop;
        timeout_d = 1'b1;
      end
    end
  end

  assign tick      = (div_cnt_q == DIV_LAST);
  assign div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;
  assign pwm_cnt_d = pwm_cnt_q + 1'b1;
  assign pwm_wrap  = &pwm_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q     <= Stop;
      timeout_q <= 1'b0;
      wd_cnt_q  <= '0;
      div_cnt_q <= '0;
      pwm_cnt_q <= '0;
    end else begin
      cmd_q     <= cmd_d;
      timeout_q <= timeout_d;
      wd_cnt_q  <= wd_cnt_d;
      div_cnt_q <= div_cnt_d;
      pwm_cnt_q <= pwm_cnt_d;
    end
  end

  // Per-wheel target {dir,duty} for the latched command.
  always_comb begin
    tl_fwd  = 1'b1;
    tr_fwd  = 1'b1;
    tl_duty = '0;
    tr_duty = '0;
    case (cmd_q)
      Fast_left: begin
        tl_fwd  = 1'b0;
        tl_duty = D_TURN;
        tr_duty = D_TURN;
      end
      Left: begin
        tl_duty = D_SLOW;
        tr_duty = D_CRUISE;
      end
      Straight: begin
        tl_duty = D_CRUISE;
        tr_duty = D_CRUISE;
      end
      Right: begin
        tl_duty = D_CRUISE;
        tr_duty = D_SLOW;
      end
      Fast_right: begin
        tl_duty = D_TURN;
        tr_fwd  = 1'b0;
        tr_duty = D_TURN;
      end
      default: ;
    endcase
  end

  wheel_channel #(
    .PWM_BITS (PWM_BITS),
    .RAMP_STEP(RAMP_STEP),
    .DEADTIME (DEADTIME)
  ) u_wheel_l (
    .clk       (clk),
    .reset     (reset),
    .tick_i    (tick),
    .wrap_i    (pwm_wrap),
    .pwm_cnt_i (pwm_cnt_q),
    .tgt_fwd_i (tl_fwd),
    .tgt_duty_i(tl_duty),
    .bridge_o  (motor_l),
    .idle_o    (idle_l)
  );

  wheel_channel #(
    .PWM_BITS (PWM_BITS),
    .RAMP_STEP(RAMP_STEP),
    .DEADTIME (DEADTIME)
  ) u_wheel_r (
    .clk       (clk),
    .reset     (reset),
    .tick_i    (tick),
    .wrap_i    (pwm_wrap),
    .pwm_cnt_i (pwm_cnt_q),
    .tgt_fwd_i (tr_fwd),
    .tgt_duty_i(tr_duty),
    .bridge_o  (motor_r),
    .idle_o    (idle_r)
  );

  assign stopped = idle_l & idle_r;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_motor_driver.sv
// Self-checking bench for motor_driver with small parameters
// (16-cycle PWM period, tick every 4 cycles, step 4, dead-time 8, watchdog 200).
module tb_motor_driver;

  localparam int PB     = 4;
  localparam int CRUISE = 12;
  localparam int SLOW   = 6;
  localparam int TURN   = 8;
  localparam int DT     = 8;
  localparam int WD     = 200;
  localparam int SETTLE = 96;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] drive_command = 3'd0;
  logic       valid = 1'b0;
  logic [1:0] motor_l, motor_r;
  logic       stopped, timeout;

  int checks = 0;
  int errors = 0;

  // High-cycle counts over one 16-cycle window: left fwd/rev, right fwd/rev.
  typedef struct packed {
    int lf;
    int lr;
    int rf;
    int rr;
  } win_t;

  win_t exp_q[$];

  motor_driver #(
    .PWM_BITS       (PB),
    .DUTY_CRUISE    (CRUISE),
    .DUTY_SLOW      (SLOW),
    .DUTY_TURN      (TURN),
    .RAMP_STEP      (4),
    .RAMP_DIV       (4),
    .DEADTIME       (DT),
    .WATCHDOG_CYCLES(WD)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .drive_command(drive_command),
    .valid        (valid),
    .motor_l      (motor_l),
    .motor_r      (motor_r),
    .stopped      (stopped),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "bench timeout");
  end

  function automatic win_t model(input logic [2:0] c);
    win_t w;
    w.lf = 0; w.lr = 0; w.rf = 0; w.rr = 0;
    case (c)
      3'd1: begin w.lr = TURN;   w.rf = TURN;   end
      3'd2: begin w.lf = SLOW;   w.rf = CRUISE; end
      3'd3: begin w.lf = CRUISE; w.rf = CRUISE; end
      3'd4: begin w.lf = CRUISE; w.rf = SLOW;   end
      3'd5: begin w.lf = TURN;   w.rr = TURN;   end
      default: ;
    endcase
    return w;
  endfunction

  task automatic set_cmd(input logic [2:0] c);
    @(negedge clk);
    drive_command = c;
    valid = 1'b1;
    exp_q.push_back(model(c));
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pops the newest expectation (older, superseded commands are dropped)
  // and compares it with a 16-cycle window of bridge outputs.
  task automatic measure(input string name);
    win_t want, got;
    int   n11;
    n11 = 0;
    got.lf = 0; got.lr = 0; got.rf = 0; got.rr = 0;
    want = got;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no expected entry queued", name);
    end else begin
      while (exp_q.size() > 1) void'(exp_q.pop_front());
      want = exp_q.pop_front();
      for (int i = 0; i < 16; i++) begin
        @(negedge clk);
        case (motor_l)
          2'b10: got.lf = got.lf + 1;
          2'b01: got.lr = got.lr + 1;
          2'b11: n11++;
          default: ;
        endcase
        case (motor_r)
          2'b10: got.rf = got.rf + 1;
          2'b01: got.rr = got.rr + 1;
          2'b11: n11++;
          default: ;
        endcase
      end
      if ((got !== want) || (n11 != 0)) begin
        errors++;
        $display("FAIL %s: got lf=%0d lr=%0d rf=%0d rr=%0d both_high=%0d, expected lf=%0d lr=%0d rf=%0d rr=%0d both_high=0",
                 name, got.lf, got.lr, got.rf, got.rr, n11, want.lf, want.lr, want.rf, want.rr);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    valid = 1'b0;
    drive_command = 3'd0;
    settle(3);
    checks++;
    if ({motor_l, motor_r, stopped, timeout} !== 6'b0000_1_0) begin
      errors++;
      $display("FAIL reset_hold: got l=%b r=%b stopped=%b timeout=%b, expected 00 00 1 0",
               motor_l, motor_r, stopped, timeout);
    end
    @(negedge clk);
    reset = 1'b0;
    settle(2);
    checks++;
    if ({motor_l, motor_r, stopped, timeout} !== 6'b0000_1_0) begin
      errors++;
      $display("FAIL reset_release: got l=%b r=%b stopped=%b timeout=%b, expected 00 00 1 0",
               motor_l, motor_r, stopped, timeout);
    end
  endtask

  task automatic test_straight();
    set_cmd(3'd3);
    @(negedge clk);
    checks++;
    if (stopped !== 1'b1) begin
      errors++;
      $display("FAIL straight_latency: stopped=%b one edge after valid, expected 1", stopped);
    end
    @(negedge clk);
    checks++;
    if (stopped !== 1'b0) begin
      errors++;
      $display("FAIL straight_stopped: stopped=%b two edges after valid, expected 0", stopped);
    end
    settle(SETTLE);
    measure("straight");
  endtask

  task automatic test_turns();
    set_cmd(3'd2); settle(SETTLE); measure("left");
    set_cmd(3'd4); settle(SETTLE); measure("right");
    set_cmd(3'd5); settle(SETTLE); measure("fast_right");
  endtask

  task automatic test_reverse();
    int last10, first01, n11, r01, gap;
    set_cmd(3'd3); settle(SETTLE); measure("reverse_pre");
    set_cmd(3'd1);
    last10 = -1; first01 = -1; n11 = 0; r01 = 0;
    for (int t = 0; t < 160; t++) begin
      @(negedge clk);
      if (motor_l == 2'b10) last10 = t;
      if ((motor_l == 2'b01) && (first01 < 0)) first01 = t;
      if ((motor_l == 2'b11) || (motor_r == 2'b11)) n11++;
      if (motor_r == 2'b01) r01++;
    end
    gap = first01 - last10 - 1;
    checks++;
    if ((first01 < 0) || (gap < DT)) begin
      errors++;
      $display("FAIL reverse_deadtime: last fwd at %0d, first rev at %0d, gap %0d, expected gap >= %0d",
               last10, first01, gap, DT);
    end
    checks++;
    if (n11 != 0) begin
      errors++;
      $display("FAIL reverse_overlap: in1&in2 high on %0d cycles, expected 0", n11);
    end
    checks++;
    if (r01 != 0) begin
      errors++;
      $display("FAIL reverse_right_dir: right reverse on %0d cycles, expected 0", r01);
    end
    measure("fast_left");
  endtask

  task automatic test_brake_revert();
    int l01, run, maxrun;
    set_cmd(3'd3); settle(SETTLE); measure("revert_pre");
    set_cmd(3'd1);
    l01 = 0; run = 0; maxrun = 0;
    for (int t = 0; t < 80; t++) begin
      @(negedge clk);
      if (t == 4) begin
        drive_command = 3'd3;
        exp_q.push_back(model(3'd3));
      end
      if (motor_l == 2'b01) l01++;
      if (motor_l == 2'b00) run++;
      else run = 0;
      if (run > maxrun) maxrun = run;
    end
    checks++;
    if (l01 != 0) begin
      errors++;
      $display("FAIL revert_dir: left reverse on %0d cycles, expected 0", l01);
    end
    checks++;
    if (maxrun >= 16) begin
      errors++;
      $display("FAIL revert_no_dead: left coasted %0d cycles in a row, expected < 16", maxrun);
    end
    measure("revert");
  endtask

  task automatic test_cmd7();
    set_cmd(3'd7);
    settle(SETTLE);
    checks++;
    if (stopped !== 1'b1) begin
      errors++;
      $display("FAIL cmd7_stopped: stopped=%b, expected 1", stopped);
    end
    measure("cmd7");
  endtask

  task automatic test_watchdog();
    set_cmd(3'd3); settle(SETTLE); measure("wd_pre");
    @(negedge clk);
    valid = 1'b0;
    settle(WD - 1);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL wd_early: timeout=%b %0d cycles after last valid, expected 0", timeout, WD - 1);
    end
    // valid lands on the expiry edge: it must win.
    drive_command = 3'd2;
    valid = 1'b1;
    exp_q.push_back(model(3'd2));
    @(negedge clk);
    valid = 1'b0;
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL wd_tie: timeout=%b after valid on expiry edge, expected 0", timeout);
    end
    settle(SETTLE);
    measure("wd_tie_left");
    settle(WD - 1 - SETTLE - 16);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL wd_early2: timeout=%b %0d cycles after last valid, expected 0", timeout, WD - 1);
    end
    exp_q.push_back(model(3'd0));
    @(negedge clk);
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL wd_fire: timeout=%b %0d cycles after last valid, expected 1", timeout, WD);
    end
    settle(SETTLE);
    checks++;
    if ({stopped, timeout} !== 2'b11) begin
      errors++;
      $display("FAIL wd_hold: stopped=%b timeout=%b, expected 1 1", stopped, timeout);
    end
    measure("wd_stop");
    drive_command = 3'd0;
    valid = 1'b1;
    @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin
      errors++;
      $display("FAIL wd_clear: timeout=%b after new valid, expected 0", timeout);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    set_cmd(3'd3);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (motor_l == 2'b10) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_wait: motor_l never reached 10 within 200 cycles");
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({motor_l, motor_r, stopped} !== 5'b0000_1) begin
      errors++;
      $display("FAIL reset_mid: got l=%b r=%b stopped=%b right after reset, expected 00 00 1",
               motor_l, motor_r, stopped);
    end
    @(negedge clk);
    reset = 1'b0;
    settle(SETTLE);
    measure("post_reset");
  endtask

  initial begin
    test_reset();
    test_straight();
    test_turns();
    test_reverse();
    test_brake_revert();
    test_cmd7();
    test_watchdog();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
